// File: rtl/rif_req_bridge.sv
// rtl/rif_req_bridge.sv - register-interface request bridge: host request queue to LMAC start/done port
// Optional hung-access timeout is built in when RIF_BRIDGE_TIMEOUT_EN is defined.
module rif_req_bridge #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int PTR     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          axis_clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mac_addr,
  output logic [DW-1:0] mac_wdata,
  output logic          mac_wr,
  output logic          mac_start,
  input  logic          mac_done,
  input  logic [DW-1:0] mac_rdata,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [AW-1:0]    q_addr  [DEPTH];
  logic [DW-1:0]    q_wdata [DEPTH];
  logic [DEPTH-1:0] q_wr;
  logic [PTR-1:0]   wr_ptr;
  logic [PTR-1:0]   rd_ptr;
  logic [PTR:0]     count;
  logic [1:0]       state;
  logic             push;
  logic             pop;
  logic             q_empty;
  logic             tmo_hit;
  logic [DW-1:0]    rdata_q;
  logic             err_q;

  assign q_empty   = (count == '0);
  assign req_ready = (count != (PTR+1)'(DEPTH));
  assign push      = req_valid & req_ready;
  assign pop       = (state == ST_IDLE) & ~q_empty;

  assign mac_start = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = ~q_empty | (state != ST_IDLE);

  // Queue storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge axis_clk) begin
    if (push) begin
      q_addr[wr_ptr]  <= req_addr;
      q_wdata[wr_ptr] <= req_wdata;
      q_wr[wr_ptr]    <= req_wr;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RIF_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Held at zero outside WAIT, so it starts clean on every entry into WAIT.
  always_ff @(posedge axis_clk) begin
    if (reset || (state != ST_WAIT)) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge axis_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mac_addr  <= '0;
      mac_wdata <= '0;
      mac_wr    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            mac_addr  <= q_addr[rd_ptr];
            mac_wdata <= q_wdata[rd_ptr];
            mac_wr    <= q_wr[rd_ptr];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mac_done) begin
            rdata_q <= mac_wr ? '0 : mac_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle takes priority over the timeout.
          if (mac_done) begin
            rdata_q <= mac_wr ? '0 : mac_rdata;
            err_q   <= 1'b0;
            state   <= ST_RESP;
          end else if (tmo_hit) begin
            rdata_q <= '1;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rif_req_bridge.sv
// tb/tb_rif_req_bridge.sv - directed scoreboard bench for rif_req_bridge
// Exercises the timeout path when RIF_BRIDGE_TIMEOUT_EN is defined.
module tb_rif_req_bridge;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          axis_clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mac_addr;
  logic [DW-1:0] mac_wdata;
  logic          mac_wr;
  logic          mac_start;
  logic          mac_done = 1'b0;
  logic [DW-1:0] mac_rdata = '0;
  logic          busy;

  rif_req_bridge #(.AW(AW), .DW(DW), .DEPTH(4), .PTR(2), .TIMEOUT(8)) dut (
    .axis_clk  (axis_clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mac_addr  (mac_addr),
    .mac_wdata (mac_wdata),
    .mac_wr    (mac_wr),
    .mac_start (mac_start),
    .mac_done  (mac_done),
    .mac_rdata (mac_rdata),
    .busy      (busy)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } mac_t;

  rsp_t rsp_q[$];
  mac_t mac_q[$];
  rsp_t rsp_exp;
  mac_t mac_exp;
  logic start_prev = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // LMAC-side and host-side monitors, sampled mid-cycle.
  always @(negedge axis_clk) begin
    if (reset) begin
      start_prev = 1'b0;
    end else begin
      if (mac_start) begin
        check("mac_start_one_cycle", start_prev, 1'b0);
        if (mac_q.size() == 0) begin
          check("unexpected_mac_start", mac_q.size(), 1);
        end else begin
          mac_exp = mac_q.pop_front();
          check("mac_addr", mac_addr, mac_exp.addr);
          check("mac_wr", mac_wr, mac_exp.wr);
          if (mac_exp.wr) check("mac_wdata", mac_wdata, mac_exp.wdata);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_q.size(), 1);
        end else begin
          rsp_exp = rsp_q.pop_front();
          check("rsp_rdata", rsp_rdata, rsp_exp.rdata);
          check("rsp_err", rsp_err, rsp_exp.err);
        end
      end
      start_prev = mac_start;
    end
  end

  task automatic push_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rdata, input logic exp_err);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check("push_ready_timeout", req_ready, 1'b1);
    mac_q.push_back('{addr: addr, wr: wr, wdata: wdata});
    rsp_q.push_back('{rdata: exp_rdata, err: exp_err});
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (mac_start !== 1'b1 && n < 100) begin tick(); n++; end
    check(tag, mac_start, 1'b1);
  endtask

  task automatic pulse_done(input logic [DW-1:0] rdata);
    mac_done  = 1'b1;
    mac_rdata = rdata;
    tick();
    mac_done  = 1'b0;
    mac_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (rsp_q.size() != 0 && n < 200) begin tick(); n++; end
    check(tag, rsp_q.size(), 0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) tick();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mac_start", mac_start, 1'b0);
    check("rst_mac_addr", mac_addr, 16'h0);
    check("rst_mac_wr", mac_wr, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;
    tick();

    // 1: read, done 3 cycles after start
    push_req(1'b0, 16'h0010, 32'h0, 32'hA5A5_0001, 1'b0);
    check("t1_start_latency", mac_start, 1'b0);
    wait_start("t1_start");
    repeat (3) tick();
    pulse_done(32'hA5A5_0001);
    wait_drain("t1_drain");

    // 1b: done coincident with the start cycle
    push_req(1'b0, 16'h0014, 32'h0, 32'h0BAD_F00D, 1'b0);
    wait_start("t1b_start");
    pulse_done(32'h0BAD_F00D);
    wait_drain("t1b_drain");

    // 2: write, done 1 cycle after start; read data must be zeroed
    push_req(1'b1, 16'h0020, 32'h1234_5678, 32'h0, 1'b0);
    wait_start("t2_start");
    check("t2_mac_wr", mac_wr, 1'b1);
    check("t2_mac_wdata", mac_wdata, 32'h1234_5678);
    tick();
    pulse_done(32'hFFFF_0000);
    wait_drain("t2_drain");

    // 3: five requests against a stalled LMAC fill the queue behind one in flight
    for (int i = 0; i < 5; i++) begin
      push_req(1'(i % 2), 16'h0100 + 16'(i), 32'h5000_0000 + 32'(i),
               (i % 2) ? 32'h0 : 32'hC0DE_0000 + 32'(i), 1'b0);
      if (i == 3) check("t3_ready_before_full", req_ready, 1'b1);
    end
    check("t3_full", req_ready, 1'b0);
    req_valid = 1'b1;
    req_addr  = 16'h0FFF;
    repeat (3) begin
      tick();
      check("t3_full_hold", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    pulse_done(32'hC0DE_0000);
    for (int i = 1; i < 5; i++) begin
      wait_start("t3_start");
      tick();
      pulse_done(32'hC0DE_0000 + 32'(i));
    end
    wait_drain("t3_drain");
    tick();
    check("t3_busy_end", busy, 1'b0);

    // 4: response backpressure and a stray done in IDLE
    rsp_ready = 1'b0;
    push_req(1'b0, 16'h0200, 32'h0, 32'h600D_0001, 1'b0);
    push_req(1'b1, 16'h0204, 32'hBBBB_0000, 32'h0, 1'b0);
    wait_start("t4_start_a");
    tick();
    pulse_done(32'h600D_0001);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("t4_rsp_valid", rsp_valid, 1'b1);
    repeat (10) begin
      check("t4_hold_valid", rsp_valid, 1'b1);
      check("t4_hold_rdata", rsp_rdata, 32'h600D_0001);
      check("t4_no_start", mac_start, 1'b0);
      check("t4_hold_addr", mac_addr, 16'h0200);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t4_gap_after_handshake", mac_start, 1'b0);
    wait_start("t4_start_b");
    tick();
    pulse_done(32'hFFFF_FFFF);
    wait_drain("t4_drain");
    tick();
    check("t4_idle", busy, 1'b0);
    pulse_done(32'h1111_2222);
    repeat (5) begin
      check("t4_stray_rsp", rsp_valid, 1'b0);
      check("t4_stray_busy", busy, 1'b0);
      tick();
    end

    // 5: hung access
`ifdef RIF_BRIDGE_TIMEOUT_EN
    rsp_ready = 1'b0;
    push_req(1'b0, 16'h0300, 32'h0, 32'hFFFF_FFFF, 1'b1);
    wait_start("t5_start");
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin tick(); n++; end
    check("t5_tmo_latency", n, 9);
    check("t5_err", rsp_err, 1'b1);
    check("t5_rdata", rsp_rdata, 32'hFFFF_FFFF);
    pulse_done(32'h1234_0000);
    check("t5_late_err", rsp_err, 1'b1);
    check("t5_late_rdata", rsp_rdata, 32'hFFFF_FFFF);
    rsp_ready = 1'b1;
    tick();
    pulse_done(32'h1234_0001);
    repeat (3) begin
      check("t5_late_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    push_req(1'b0, 16'h0304, 32'h0, 32'h7777_0008, 1'b0);
    wait_start("t5_tie_start");
    repeat (8) tick();
    pulse_done(32'h7777_0008);
    wait_drain("t5_tie_drain");
`else
    push_req(1'b0, 16'h0300, 32'h0, 32'h5A5A_5A5A, 1'b0);
    wait_start("t5_start");
    repeat (20) tick();
    check("t5_still_waiting", rsp_valid, 1'b0);
    check("t5_still_busy", busy, 1'b1);
    pulse_done(32'h5A5A_5A5A);
    wait_drain("t5_drain");
`endif

    // 6: reset during WAIT with two requests queued
    push_req(1'b0, 16'h0400, 32'h0, 32'h0, 1'b0);
    push_req(1'b0, 16'h0404, 32'h0, 32'h0, 1'b0);
    push_req(1'b0, 16'h0408, 32'h0, 32'h0, 1'b0);
    check("t6_in_wait", mac_start, 1'b0);
    check("t6_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mac_q.delete();
    rsp_q.delete();
    check("t6_busy", busy, 1'b0);
    check("t6_req_ready", req_ready, 1'b1);
    check("t6_rsp_valid", rsp_valid, 1'b0);
    check("t6_mac_addr", mac_addr, 16'h0);
    pulse_done(32'h9999_9999);
    repeat (5) begin
      check("t6_post_rsp", rsp_valid, 1'b0);
      check("t6_post_start", mac_start, 1'b0);
      check("t6_post_busy", busy, 1'b0);
      tick();
    end

    // recovery after reset
    push_req(1'b0, 16'h0500, 32'h0, 32'h0E0E_0E0E, 1'b0);
    wait_start("t7_start");
    tick();
    pulse_done(32'h0E0E_0E0E);
    wait_drain("t7_drain");
    check("t7_mac_q_empty", mac_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
